probe_uplink_arbiter: RTL and testbench
=======================================

# probe_uplink_arbiter

Shares one 32-bit probe uplink between `NumProbes` probe-value channels. Each channel presents a message (header word whose low byte is the body word count N, then N body words) on its own DATAUP/DATAVALID/ACK port. The arbiter grants channels round-robin, holds the grant for one whole message, and registers every word into a single output stage toward the serial transport. Sits on UCLK between the probe instances and the uplink serializer.

## Interface
- `NumProbes`, 4, number of channels, 2..16
- `TimeoutCycles`, 255, stall limit for a granted channel (used only with the timeout feature), 1..65535
- UCLK  in  1  uplink clock; all logic on posedge
- URST  in  1  asynchronous, active-high reset
- PDATA  in  32*NumProbes  channel words; channel i = bits [32i+31:32i]
- PVALID  in  NumProbes  channel word valid (probe DATAVALID)
- PDELAY  in  NumProbes  channel has pending data (probe DELAY)
- PACK  out  NumProbes  one-cycle accept pulse to granted channel
- DATAUP  out  32  registered output word
- DATAVALID  out  1  DATAUP holds a word
- ACK  in  1  downstream consumed DATAUP this cycle
- DELAY  out  1  OR of PDELAY
- BUSY  out  1  a message is granted
- GRANTID  out  4  index of granted channel, valid while BUSY
- TOERR  out  1  sticky timeout flag (0 when feature compiled out)

## Operation
- States: IDLE, HDR, BODY.
- IDLE: if any PVALID, pick first requester at or after `ptr` (round-robin), register GRANTID, go HDR. No PVALID: stay.
- Load condition `ld` = PVALID[g] && (!DATAVALID || ACK). On `ld`: DATAUP <= PDATA[g], DATAVALID <= 1, PACK[g] = 1 (combinational, same cycle). Without `ld`, if ACK, DATAVALID <= 0.
- HDR on `ld`: rem <= PDATA[g][7:0]; if that count is 0, message ends; else go BODY.
- BODY on `ld`: rem <= rem-1; if rem==1, message ends.
- Message end: go IDLE, ptr <= g+1 (mod NumProbes, wrapping to 0 past NumProbes-1), BUSY falls next cycle.
- PACK only to granted channel, never while IDLE. Non-granted PVALID is ignored and stays pending.
- DELAY is combinational OR, independent of state.
- Reset: state IDLE, ptr 0, rem 0, DATAVALID 0, DATAUP 0, BUSY 0, GRANTID 0, TOERR 0, PACK 0.

## Timing
- PVALID seen in IDLE at cycle 0. Grant registered at edge 0→1. Header `ld` in cycle 1. DATAVALID high in cycle 2.
- Body words stream one per cycle while ACK is held high, because the probe updates its word the cycle after PACK.
- ACK with DATAVALID low is ignored. A simultaneous ACK and `ld` replaces the word with no bubble.
- One IDLE arbitration cycle occurs between consecutive messages.
- Max message is 256 words (N=255). rem is 8 bits and never underflows.
- URST mid-message drops the message immediately. Probes are reset on their own domain.

## Configuration
- `PROBE_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs while in HDR/BODY with PVALID[g]=0 and clears on every `ld`.
  - When the counter reaches TimeoutCycles, the arbiter aborts to IDLE, advances ptr, and sets TOERR sticky until reset.
  - The partially sent message is not padded.
- Undefined: no counter. A stalled granted channel holds the grant indefinitely. TOERR is tied 0.

## Structure
- Package `probe_arb_pkg` holds:
  - state enum (IDLE/HDR/BODY)
  - header count field position [7:0] and probe-id field position [31:16]
  - width constants (word 32, count 8, grant index 4)
- Sub-module `rr_arbiter`: NumProbes request vector plus ptr, producing a one-hot grant and an index; purely combinational.

## Test plan
- Single message:
  - Stimulus: ch1 sends header 0x0001_0002 then words 0xA, 0xB; ACK held 1.
  - Response: DATAUP sequence 0x00010002, 0xA, 0xB in cycles 2–4; exactly 3 PACK[1] pulses; BUSY low at cycle 5.
- Round-robin:
  - Stimulus: ch0 and ch2 both request continuously with N=0.
  - Response: grants alternate 0,2,0,2. After ch2 is granted, ptr=3 so ch0 (wrap) is granted next.
- Backpressure:
  - Stimulus: N=3 message, ACK toggling 1,0,1,0.
  - Response: PACK is asserted only when !DATAVALID||ACK. No word is lost or duplicated, and all 4 words are delivered in order.
- Zero-count header:
  - Stimulus: header 0x0005_0000.
  - Response: the message ends on the header, the arbiter returns to IDLE, and there is one PACK.
- Timeout (`PROBE_ARB_TIMEOUT_EN`, TimeoutCycles=8):
  - Stimulus: ch3 drops PVALID after the header.
  - Response: 8 cycles later the state is IDLE, TOERR=1, and ch0 gets the next grant.
- Reset mid-BODY:
  - Stimulus: assert URST during a message.
  - Response: same cycle, DATAVALID=0 and BUSY=0; after release, IDLE with ptr=0.

Source files
------------

// File: rtl/probe_arb_pkg.sv
// rtl/probe_arb_pkg.sv - shared types, field positions and widths for the probe uplink arbiter
package probe_arb_pkg;

  localparam int WordW  = 32;
  localparam int CountW = 8;
  localparam int GrantW = 4;

  // Header word layout: low byte is the body word count, upper half is the probe id.
  localparam int CountLsb = 0;
  localparam int CountMsb = 7;
  localparam int IdLsb    = 16;
  localparam int IdMsb    = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } arb_state_t;

  function automatic logic [CountW-1:0] hdr_count(input logic [WordW-1:0] word);
    return word[CountMsb:CountLsb];
  endfunction

  function automatic logic [IdMsb-IdLsb:0] hdr_probe_id(input logic [WordW-1:0] word);
    return word[IdMsb:IdLsb];
  endfunction

endpackage

// File: rtl/probe_uplink_arbiter_rr_arbiter.sv
// rtl/probe_uplink_arbiter_rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
// Ports:
//   req  in   NumProbes  request vector (one bit per channel)
//   ptr  in   4          highest-priority channel index this round
//   gnt  out  NumProbes  one-hot grant (all zero when no request)
//   idx  out  4          index of the granted channel
//   any  out  1          at least one request present
module rr_arbiter
  import probe_arb_pkg::*;
#(
  parameter int NumProbes = 4
) (
  input  logic [NumProbes-1:0] req,
  input  logic [GrantW-1:0]    ptr,
  output logic [NumProbes-1:0] gnt,
  output logic [GrantW-1:0]    idx,
  output logic                 any
);

  localparam logic [GrantW:0] NumSlots = (GrantW+1)'(NumProbes);

  logic [NumProbes-1:0] rot;
  logic [GrantW-1:0]    pos;
  logic [GrantW:0]      slot;

  always_comb begin
    // Rotate so that bit 0 is the channel at ptr; the lowest set bit is the winner.
    rot = NumProbes'({req, req} >> ptr);
    any = |req;
    pos = '0;
    for (int k = NumProbes - 1; k >= 0; k--) begin
      if (rot[k]) pos = GrantW'(k);
    end
    slot = {1'b0, ptr} + {1'b0, pos};
    if (slot >= NumSlots) slot = slot - NumSlots;
    idx = slot[GrantW-1:0];
    gnt = '0;
    for (int i = 0; i < NumProbes; i++) begin
      if (any && (slot == (GrantW+1)'(i))) gnt[i] = 1'b1;
    end
  end

endmodule

// File: rtl/probe_uplink_arbiter.sv
// rtl/probe_uplink_arbiter.sv - round-robin message arbiter sharing one 32-bit probe uplink
// Optional feature macro: PROBE_ARB_TIMEOUT_EN (abort a stalled grant after TimeoutCycles).
// Ports:
//   UCLK       in   1             uplink clock, posedge
//   URST       in   1             asynchronous active-high reset
//   PDATA      in   32*NumProbes  channel words, channel i at [32i+31:32i]
//   PVALID     in   NumProbes     channel word valid
//   PDELAY     in   NumProbes     channel has pending data
//   PACK       out  NumProbes     accept pulse to the granted channel
//   DATAUP     out  32            registered output word
//   DATAVALID  out  1             DATAUP holds a word
//   ACK        in   1             downstream consumed DATAUP
//   DELAY      out  1             OR of PDELAY
//   BUSY       out  1             a message is granted
//   GRANTID    out  4             granted channel index
//   TOERR      out  1             sticky timeout flag
module probe_uplink_arbiter
  import probe_arb_pkg::*;
#(
  parameter int NumProbes     = 4,
  parameter int TimeoutCycles = 255
) (
  input  logic                      UCLK,
  input  logic                      URST,
  input  logic [WordW*NumProbes-1:0] PDATA,
  input  logic [NumProbes-1:0]      PVALID,
  input  logic [NumProbes-1:0]      PDELAY,
  output logic [NumProbes-1:0]      PACK,
  output logic [WordW-1:0]          DATAUP,
  output logic                      DATAVALID,
  input  logic                      ACK,
  output logic                      DELAY,
  output logic                      BUSY,
  output logic [GrantW-1:0]         GRANTID,
  output logic                      TOERR
);

  if (NumProbes < 2 || NumProbes > 16 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_param_check
    $error("probe_uplink_arbiter: parameter out of range");
  end

  arb_state_t           state;
  logic [GrantW-1:0]    ptr;
  logic [CountW-1:0]    rem;
  logic [NumProbes-1:0] grant_oh;

  logic [NumProbes-1:0] arb_gnt;
  logic [GrantW-1:0]    arb_idx;
  logic                 arb_any;

  logic [WordW-1:0]     pdata_g;
  logic                 pvalid_g;
  logic                 ld;
  logic [GrantW-1:0]    next_ptr;

  rr_arbiter #(
    .NumProbes(NumProbes)
  ) u_rr (
    .req(PVALID),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  // Select the granted channel's word and valid with the registered one-hot grant.
  always_comb begin
    pdata_g  = '0;
    pvalid_g = 1'b0;
    for (int i = 0; i < NumProbes; i++) begin
      if (grant_oh[i]) begin
        pdata_g  = PDATA[WordW*i +: WordW];
        pvalid_g = PVALID[i];
      end
    end
  end

  // The output stage accepts a new word when empty or being drained this cycle.
  assign ld       = (state != IDLE) && pvalid_g && (!DATAVALID || ACK);
  assign PACK     = {NumProbes{ld}} & grant_oh;
  assign DELAY    = |PDELAY;
  assign next_ptr = (GRANTID == GrantW'(NumProbes - 1)) ? '0 : GRANTID + GrantW'(1);

`ifdef PROBE_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        stall_hit;
  assign stall_hit = (state != IDLE) && !pvalid_g && (stall_cnt == 16'(TimeoutCycles - 1));
`else
  assign TOERR = 1'b0;
`endif

  always_ff @(posedge UCLK or posedge URST) begin
    if (URST) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      grant_oh  <= '0;
      DATAUP    <= '0;
      DATAVALID <= 1'b0;
      BUSY      <= 1'b0;
      GRANTID   <= '0;
`ifdef PROBE_ARB_TIMEOUT_EN
      stall_cnt <= '0;
      TOERR     <= 1'b0;
`endif
    end else begin
      if (ld) begin
        DATAUP    <= pdata_g;
        DATAVALID <= 1'b1;
      end else if (ACK) begin
        DATAVALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_oh <= arb_gnt;
            GRANTID  <= arb_idx;
            BUSY     <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (ld) begin
            rem <= hdr_count(pdata_g);
            if (hdr_count(pdata_g) == '0) begin
              state <= IDLE;
              BUSY  <= 1'b0;
              ptr   <= next_ptr;
            end else begin
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (ld) begin
            rem <= rem - CountW'(1);
            if (rem == CountW'(1)) begin
              state <= IDLE;
              BUSY  <= 1'b0;
              ptr   <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase

`ifdef PROBE_ARB_TIMEOUT_EN
      if (state == IDLE || ld) begin
        stall_cnt <= '0;
      end else if (!pvalid_g) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      // Abort drops the partial message as-is; no padding words are generated.
      if (stall_hit) begin
        state     <= IDLE;
        BUSY      <= 1'b0;
        ptr       <= next_ptr;
        TOERR     <= 1'b1;
        stall_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_probe_uplink_arbiter.sv
// tb/tb_probe_uplink_arbiter.sv - directed self-checking bench for probe_uplink_arbiter
module tb_probe_uplink_arbiter;

  logic         UCLK = 1'b0;
  logic         URST;
  logic [31:0]  pd [4];
  logic [127:0] PDATA;
  logic [3:0]   PVALID;
  logic [3:0]   PDELAY;
  logic [3:0]   PACK;
  logic [31:0]  DATAUP;
  logic         DATAVALID;
  logic         ACK;
  logic         DELAY;
  logic         BUSY;
  logic [3:0]   GRANTID;
  logic         TOERR;

  int total = 0;
  int bad   = 0;

  assign PDATA = {pd[3], pd[2], pd[1], pd[0]};

  always #5 UCLK = ~UCLK;

  probe_uplink_arbiter #(
    .NumProbes(4),
    .TimeoutCycles(8)
  ) dut (
    .UCLK(UCLK),
    .URST(URST),
    .PDATA(PDATA),
    .PVALID(PVALID),
    .PDELAY(PDELAY),
    .PACK(PACK),
    .DATAUP(DATAUP),
    .DATAVALID(DATAVALID),
    .ACK(ACK),
    .DELAY(DELAY),
    .BUSY(BUSY),
    .GRANTID(GRANTID),
    .TOERR(TOERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UCLK);
    #1;
  endtask

  // Backpressure vectors, one row per cycle: probe word, probe valid, ACK,
  // expected PACK[0], expected DATAVALID, expected DATAUP (checked when valid).
  logic [31:0] bp_pd   [9] = '{32'h0000_CC03, 32'h0000_CC03, 32'h11, 32'h22, 32'h22,
                               32'h33, 32'h33, 32'h0, 32'h0};
  logic        bp_pv   [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic        bp_ack  [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
  logic        bp_pack [9] = '{0, 1, 1, 0, 1, 0, 1, 0, 0};
  logic        bp_dv   [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
  logic [31:0] bp_du   [9] = '{32'h0, 32'h0, 32'h0000_CC03, 32'h11, 32'h11,
                               32'h22, 32'h22, 32'h33, 32'h33};

  initial begin
    URST   = 1'b0;
    PVALID = '0;
    PDELAY = '0;
    ACK    = 1'b0;
    for (int i = 0; i < 4; i++) pd[i] = '0;
    #2 URST = 1'b1;
    tick();
    #1;
    chk("rst_datavalid", 32'(DATAVALID), 32'd0);
    chk("rst_dataup", DATAUP, 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_grantid", 32'(GRANTID), 32'd0);
    chk("rst_toerr", 32'(TOERR), 32'd0);
    chk("rst_pack", 32'(PACK), 32'd0);
    PDELAY = 4'b0100;
    #1 chk("delay_or_hi", 32'(DELAY), 32'd1);
    PDELAY = 4'b0000;
    #1 chk("delay_or_lo", 32'(DELAY), 32'd0);
    URST = 1'b0;

    // Single message on ch1, ACK held high.
    ACK = 1'b1;
    tick(); pd[1] = 32'h0001_0002; PVALID = 4'b0010;
    #1 chk("sm_c0_busy", 32'(BUSY), 32'd0);
    chk("sm_c0_pack", 32'(PACK), 32'd0);
    tick();
    #1 chk("sm_c1_grantid", 32'(GRANTID), 32'd1);
    chk("sm_c1_busy", 32'(BUSY), 32'd1);
    chk("sm_c1_pack", 32'(PACK), 32'b0010);
    chk("sm_c1_dv", 32'(DATAVALID), 32'd0);
    tick(); pd[1] = 32'hA;
    #1 chk("sm_c2_dataup", DATAUP, 32'h0001_0002);
    chk("sm_c2_dv", 32'(DATAVALID), 32'd1);
    chk("sm_c2_pack", 32'(PACK), 32'b0010);
    tick(); pd[1] = 32'hB;
    #1 chk("sm_c3_dataup", DATAUP, 32'hA);
    chk("sm_c3_pack", 32'(PACK), 32'b0010);
    tick(); PVALID = 4'b0000;
    #1 chk("sm_c4_dataup", DATAUP, 32'hB);
    chk("sm_c4_pack", 32'(PACK), 32'd0);
    tick();
    #1 chk("sm_c5_busy", 32'(BUSY), 32'd0);
    chk("sm_c5_dv", 32'(DATAVALID), 32'd0);

    // Reset pulse so round-robin starts from ptr 0.
    URST = 1'b1;
    tick(); URST = 1'b0;

    // Round-robin between ch0 and ch2, zero-count headers.
    pd[0] = 32'h0000_AA00; pd[2] = 32'h0002_BB00; PVALID = 4'b0101;
    for (int m = 0; m < 4; m++) begin
      tick();
      #1 chk($sformatf("rr%0d_grantid", m), 32'(GRANTID), (m % 2 == 0) ? 32'd0 : 32'd2);
      chk($sformatf("rr%0d_pack", m), 32'(PACK), (m % 2 == 0) ? 32'b0001 : 32'b0100);
      tick();
      if (m == 3) PVALID = 4'b0000;
      #1 chk($sformatf("rr%0d_dataup", m), DATAUP, (m % 2 == 0) ? 32'h0000_AA00 : 32'h0002_BB00);
    end
    tick();
    #1 chk("rr_end_busy", 32'(BUSY), 32'd0);

    // Backpressure: ch0 N=3 with ACK toggling; ptr is 3 so ch0 wins by wrap.
    for (int c = 0; c < 9; c++) begin
      tick();
      pd[0] = bp_pd[c]; PVALID = {3'b000, bp_pv[c]}; ACK = bp_ack[c];
      #1 chk($sformatf("bp_c%0d_pack", c), 32'(PACK), {31'd0, bp_pack[c]});
      chk($sformatf("bp_c%0d_dv", c), 32'(DATAVALID), {31'd0, bp_dv[c]});
      if (bp_dv[c]) chk($sformatf("bp_c%0d_dataup", c), DATAUP, bp_du[c]);
      if (c == 1) chk("bp_grantid", 32'(GRANTID), 32'd0);
    end
    tick();
    #1 chk("bp_end_dv", 32'(DATAVALID), 32'd0);
    chk("bp_end_busy", 32'(BUSY), 32'd0);

    // Zero-count header on ch3; ch2 requests meanwhile and must wait.
    tick(); pd[3] = 32'h0005_0000; PVALID = 4'b1000;
    tick(); pd[2] = 32'h0002_DD00; PVALID = 4'b1100;
    #1 chk("zc_c1_grantid", 32'(GRANTID), 32'd3);
    chk("zc_c1_pack", 32'(PACK), 32'b1000);
    tick(); PVALID = 4'b0100;
    #1 chk("zc_c2_busy", 32'(BUSY), 32'd0);
    chk("zc_c2_pack", 32'(PACK), 32'd0);
    chk("zc_c2_dataup", DATAUP, 32'h0005_0000);
    tick();
    #1 chk("zc_c3_grantid", 32'(GRANTID), 32'd2);
    chk("zc_c3_pack", 32'(PACK), 32'b0100);
    tick(); PVALID = 4'b0000;
    #1 chk("zc_c4_dataup", DATAUP, 32'h0002_DD00);

    // Stalled ch1 message with ACK low, then reset mid-body.
    tick(); pd[1] = 32'h0001_0002; PVALID = 4'b0010; ACK = 1'b0;
    tick();
    #1 chk("st_c1_pack", 32'(PACK), 32'b0010);
    tick(); PVALID = 4'b0000;
    #1 chk("st_c2_dataup", DATAUP, 32'h0001_0002);
    chk("st_c2_busy", 32'(BUSY), 32'd1);
    repeat (10) tick();
`ifdef PROBE_ARB_TIMEOUT_EN
    chk("st_timeout_busy", 32'(BUSY), 32'd0);
    chk("st_timeout_toerr", 32'(TOERR), 32'd1);
`else
    chk("st_hold_busy", 32'(BUSY), 32'd1);
    chk("st_hold_grantid", 32'(GRANTID), 32'd1);
    chk("st_hold_toerr", 32'(TOERR), 32'd0);
`endif
    chk("st_dv_held", 32'(DATAVALID), 32'd1);
    URST = 1'b1;
    #1 chk("rb_dv", 32'(DATAVALID), 32'd0);
    chk("rb_busy", 32'(BUSY), 32'd0);
    chk("rb_toerr", 32'(TOERR), 32'd0);
    tick(); URST = 1'b0;
    pd[1] = 32'h0001_EE00; pd[3] = 32'h0003_FF00; PVALID = 4'b1010; ACK = 1'b1;
    tick();
    #1 chk("rb_ptr0_grantid", 32'(GRANTID), 32'd1);
    chk("rb_ptr0_pack", 32'(PACK), 32'b0010);
    tick(); PVALID = 4'b1000;
    #1 chk("rb_dataup", DATAUP, 32'h0001_EE00);
    tick();
    #1 chk("rb_next_grantid", 32'(GRANTID), 32'd3);
    chk("rb_next_pack", 32'(PACK), 32'b1000);
    tick(); PVALID = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
